// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 fetch path: PC sequencer states and default vectors.
package mips32_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
  localparam int          DEFAULT_STEP         = 4;

endpackage

// File: rtl/pc_reg.sv
// Generic WIDTH-bit register with synchronous reset value and load enable.
module pc_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with one branch delay slot, stall and exception redirect.
// Optional PC_ALIGN_CHECK_EN adds a misalign pulse and forces captured targets onto STEP alignment.
module pc_unit
  import mips32_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = DEFAULT_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_prev,
  output logic             in_slot,
  output logic [WIDTH-1:0] epc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_t        state, state_next;
  logic             pc_en, epc_en, tq_en;
  logic [WIDTH-1:0] pc_d, epc_d, tq_d, target_q, tq_capture;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  assign in_slot = (state == SLOT);

  // Exception beats stall; the delay slot reports the branch itself as the return point.
  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    pc_d       = pc;
    epc_en     = 1'b0;
    epc_d      = epc;
    tq_en      = 1'b0;
    tq_d       = target_q;
    if (exc) begin
      pc_en      = 1'b1;
      pc_d       = EXC_VECTOR;
      epc_en     = 1'b1;
      epc_d      = in_slot ? pc_prev : pc;
      tq_en      = 1'b1;
      tq_d       = '0;
      state_next = RUN;
    end else if (!stall) begin
      pc_en = 1'b1;
      if (state == SLOT) begin
        pc_d       = target_q;
        state_next = RUN;
      end else begin
        pc_d = pc + STEP_W;
        if (br_taken) begin
          tq_en      = 1'b1;
          tq_d       = tq_capture;
          state_next = SLOT;
        end
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic tq_mis;

  assign tq_capture = br_target & ~ALIGN_MASK;

  // Remember a trimmed target so the pulse lines up with the cycle pc shows it.
  always_ff @(posedge clock) begin
    if (reset) begin
      tq_mis   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (tq_en) begin
        tq_mis <= !exc && (|(br_target & ALIGN_MASK));
      end
      misalign <= !exc && !stall && (state == SLOT) && tq_mis;
    end
  end
`else
  assign tq_capture = br_target;
`endif

  pc_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VECTOR)) u_pc (
    .clock(clock), .reset(reset), .en(pc_en), .d(pc_d), .q(pc)
  );

  pc_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VECTOR)) u_pc_prev (
    .clock(clock), .reset(reset), .en(pc_en), .d(pc), .q(pc_prev)
  );

  pc_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_epc (
    .clock(clock), .reset(reset), .en(epc_en), .d(epc_d), .q(epc)
  );

  pc_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_target (
    .clock(clock), .reset(reset), .en(tq_en), .d(tq_d), .q(target_q)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed literal checks plus randomized traffic against a reference model.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset, stall, br_taken, exc;
  logic [31:0] br_target;
  logic [31:0] pc, pc_prev, epc;
  logic        in_slot;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference state: architectural PC view plus a queue of redirects still owed.
  logic [31:0] m_pc, m_prev, m_epc;
  logic [31:0] pend[$];
  bit          m_mis;

  always #5 clock = ~clock;

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .exc(exc), .pc(pc), .pc_prev(pc_prev),
    .in_slot(in_slot), .epc(epc)
`ifdef PC_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  function automatic logic [31:0] landing(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t & ~32'h3;
`else
    return t;
`endif
  endfunction

  always @(posedge clock) begin
    m_mis = 1'b0;
    if (reset) begin
      m_pc   = 32'h0;
      m_prev = 32'h0;
      m_epc  = 32'h0;
      pend.delete();
    end else if (exc) begin
      m_epc  = (pend.size() != 0) ? m_prev : m_pc;
      m_prev = m_pc;
      m_pc   = 32'h80;
      pend.delete();
    end else if (!stall) begin
      m_prev = m_pc;
      if (pend.size() != 0) begin
        m_pc  = landing(pend[0]);
        m_mis = (pend[0][1:0] != 2'b00);
        pend.delete();
      end else begin
        m_pc = m_pc + 32'd4;
        if (br_taken) pend.push_back(br_target);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_pc", pc, m_pc);
      checkOutput("model_pc_prev", pc_prev, m_prev);
      checkOutput("model_epc", epc, m_epc);
      checkOutput("model_in_slot", {31'b0, in_slot}, {31'b0, pend.size() != 0});
`ifdef PC_ALIGN_CHECK_EN
      checkOutput("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
`endif
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit b,
                               input logic [31:0] t, input bit e);
    reset     = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    exc       = e;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic freeRun(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 32'h0, 0);
  endtask

  logic [31:0] exp_prev[4] = '{32'h0, 32'h0, 32'h4, 32'h8};

  initial begin
    applyStimulus(1, 0, 0, 32'h0, 0);
    check_en = 1'b1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pc_prev", pc_prev, 32'h0);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_in_slot", {31'b0, in_slot}, 32'h0);

    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("seq_pc", pc, 32'(i * 4));
      checkOutput("seq_pc_prev", pc_prev, exp_prev[i]);
    end

    freeRun(1);
    checkOutput("pre_branch_pc", pc, 32'h10);
    applyStimulus(0, 0, 1, 32'h200, 0);
    checkOutput("slot_pc", pc, 32'h14);
    checkOutput("slot_flag", {31'b0, in_slot}, 32'h1);
    applyStimulus(0, 0, 1, 32'h300, 0);
    checkOutput("target_pc", pc, 32'h200);
    checkOutput("target_slot_clear", {31'b0, in_slot}, 32'h0);

    applyStimulus(1, 0, 0, 32'h0, 0);
    freeRun(4);
    applyStimulus(0, 0, 1, 32'h200, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkOutput("stall_hold_pc", pc, 32'h14);
      checkOutput("stall_hold_slot", {31'b0, in_slot}, 32'h1);
    end
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("stall_release_pc", pc, 32'h200);

    applyStimulus(1, 0, 0, 32'h0, 0);
    freeRun(4);
    applyStimulus(0, 0, 1, 32'h200, 0);
    applyStimulus(0, 1, 0, 32'h0, 1);
    checkOutput("exc_pc", pc, 32'h80);
    checkOutput("exc_epc", epc, 32'h10);
    checkOutput("exc_slot", {31'b0, in_slot}, 32'h0);
    freeRun(1);
    checkOutput("exc_no_jump", pc, 32'h84);

    freeRun(1);
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
    checkOutput("wrap_slot_pc", pc, 32'h8C);
    freeRun(1);
    checkOutput("wrap_top_pc", pc, 32'hFFFF_FFFC);
    freeRun(1);
    checkOutput("wrap_pc", pc, 32'h0);

    applyStimulus(0, 0, 1, 32'h400, 0);
    applyStimulus(1, 1, 0, 32'h0, 1);
    checkOutput("rst_override_pc", pc, 32'h0);
    checkOutput("rst_override_slot", {31'b0, in_slot}, 32'h0);
    freeRun(1);
    checkOutput("post_rst_pc", pc, 32'h4);

`ifdef PC_ALIGN_CHECK_EN
    applyStimulus(0, 0, 1, 32'h203, 0);
    freeRun(1);
    checkOutput("align_pc", pc, 32'h200);
    checkOutput("align_pulse", {31'b0, misalign}, 32'h1);
    freeRun(1);
    checkOutput("align_pulse_end", {31'b0, misalign}, 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, tgt, $urandom_range(0, 15) == 0);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the PC width in bits.
REQ-002 The block SHALL take parameter STEP, default 4, as the sequential increment; STEP SHALL be a power of two.
REQ-003 The block SHALL take parameter RESET_VECTOR, default 32'h0000_0000, as the PC loaded on reset.
REQ-004 The block SHALL take parameter EXC_VECTOR, default 32'h0000_0080, as the PC loaded on exception.
REQ-005 The block SHALL have port clock, input, width 1, as the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port stall, input, width 1; 1 means hold all state and ignore br_taken.
REQ-008 The block SHALL have port br_taken, input, width 1; 1 means a taken branch or jump is in decode this cycle.
REQ-009 The block SHALL have port br_target, input, WIDTH bits, as the redirect target qualified by br_taken.
REQ-010 The block SHALL have port exc, input, width 1, as an exception request; it is honoured even while stalled.
REQ-011 The block SHALL have port pc, output, WIDTH bits, as the current fetch address (registered).
REQ-012 The block SHALL have port pc_prev, output, WIDTH bits, as the PC held before the last update (registered).
REQ-013 The block SHALL have port in_slot, output, width 1; 1 means the current pc is a branch delay slot.
REQ-014 The block SHALL have port epc, output, WIDTH bits, as the exception return address (registered).

Function
REQ-015 The block SHALL implement a 2-state FSM: RUN (no redirect pending) and SLOT (delay slot fetching, target pending).
REQ-016 In RUN with stall=0 and br_taken=0, the block SHALL perform pc<=pc+STEP.
REQ-017 In RUN with stall=0 and br_taken=1, the block SHALL capture target_q<=br_target, set pc<=pc+STEP, move to SLOT and set in_slot to 1.
REQ-018 In SLOT with stall=0, the block SHALL set pc<=target_q, return to RUN and clear in_slot; br_taken in SLOT SHALL be ignored.
REQ-019 The target SHALL appear on pc exactly 2 unstalled cycles after the br_taken cycle.
REQ-020 The pc+STEP addition SHALL wrap modulo 2^WIDTH with no flag.
REQ-021 With stall=1 and exc=0, pc, pc_prev, target_q, the FSM and in_slot SHALL hold; a stall in SLOT SHALL keep the pending target.
REQ-022 exc=1 SHALL have top priority, regardless of stall or state: pc<=EXC_VECTOR, FSM<=RUN, in_slot<=0, and the pending target discarded.
REQ-023 On exc, epc SHALL get pc_prev if in_slot=1 (the branch), else pc.
REQ-024 pc_prev SHALL get the old pc on every pc update (advance, redirect, exception) and hold otherwise.

Reset
REQ-025 reset=1 SHALL override exc and stall.
REQ-026 On reset, the block SHALL set pc=RESET_VECTOR, pc_prev=RESET_VECTOR, epc=0, target_q=0, FSM=RUN and in_slot=0.
REQ-027 Reset during SLOT SHALL discard the pending target, and the first post-reset advance SHALL be RESET_VECTOR+STEP.

Configuration
REQ-028 When PC_ALIGN_CHECK_EN is defined, the block SHALL add output port misalign (width 1, reset 0) and check the low log2(STEP) bits of br_target when it is captured.
REQ-029 With PC_ALIGN_CHECK_EN defined, a nonzero misaligned captured br_target SHALL have those bits cleared in target_q, and misalign SHALL pulse high for 1 cycle in the cycle pc loads target_q.
REQ-030 Without PC_ALIGN_CHECK_EN, the misalign port and its logic SHALL be absent and br_target SHALL be loaded unmodified.

Structure
REQ-031 Shared package mips32_pkg SHALL hold the FSM state typedef (RUN, SLOT), the default RESET_VECTOR/EXC_VECTOR constants and the default STEP.
REQ-032 The block SHALL instantiate one sub-module, pc_reg: a WIDTH-parameterised register with sync reset value, load enable and data input, used for pc, pc_prev, epc and target_q.

Verification
REQ-033 Reset then 3 free cycles SHALL give pc 0x00, 0x04, 0x08, 0x0C and pc_prev 0x00, 0x00, 0x04, 0x08.
REQ-034 At pc=0x10, br_taken=1 with br_target=0x200 SHALL give next pc 0x14 with in_slot=1, then pc 0x200 with in_slot=0.
REQ-035 Branch at pc=0x10 and stall=1 for 3 cycles while in SLOT SHALL hold pc at 0x14; after the stall releases, pc SHALL be 0x200.
REQ-036 exc=1 while in_slot=1 at pc=0x14 (branch at 0x10) SHALL give pc=0x80, epc=0x10 and in_slot=0, with no later jump to 0x200.
REQ-037 With WIDTH=32, pc=0xFFFF_FFFC and no branch, the next pc SHALL be 0x0000_0000.
REQ-038 With PC_ALIGN_CHECK_EN defined, br_target=0x203 SHALL load pc 0x200 after the slot with misalign high for exactly that one cycle.
